// File: rtl/sram_frame_arbiter.sv
// sram_frame_arbiter: owns the single-port frame-buffer SRAM.
// Arbitrates one pixel writer against one pixel reader and manages ping-pong
// selection between the two frame buffers at addr0/addr1. The reader is
// never pointed at a frame that is still being written.
// Build option: define SRAM_ARB_WR_PRIORITY_EN for fixed write priority;
// leave it undefined for round-robin arbitration.
module sram_frame_arbiter #(
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 2     // legal range 1..4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic                  wr_frame_start,
    input  logic                  wr_frame_end,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_offset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_gnt,
    input  logic                  rd_frame_start,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_offset,
    output logic                  rd_gnt,
    output logic                  rd_dv,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wr_buf_sel,
    output logic                  rd_buf_sel,
    output logic                  frame_drop,
    output logic                  frame_repeat,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_ceb,
    output logic                  sram_web,
    output logic                  sram_oeb,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    output logic                  sram_wdata_oe,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    // Which requester won the most recent accepted transfer.
    typedef enum logic {
        LAST_RD = 1'b0,
        LAST_WR = 1'b1
    } rr_e;

    logic wr_xfer;
    logic rd_xfer;

    // Frame-buffer bookkeeping: the most recently completed frame and
    // whether the writer is currently inside a frame.
    logic done_valid;
    logic done_sel;
    logic wr_active;

    logic rd_sel_nxt;
    logic wr_sel_nxt;
    logic done_valid_nxt;
    logic done_sel_nxt;
    logic wr_active_nxt;
    logic drop_nxt;
    logic repeat_nxt;

    // One bit per read command still travelling through the SRAM.
    logic [RD_LATENCY-1:0] rd_vpipe;

`ifdef SRAM_ARB_WR_PRIORITY_EN
    // Fixed priority: the incoming stream always wins, reads take idle slots.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned; an unassigned path would infer a latch.
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (enable && !reset) begin
            wr_gnt = wr_req;
            rd_gnt = rd_req && !wr_req;
        end
    end
`else
    rr_e rr_last;

    // Round-robin grant: on contention the side not served last wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned; an unassigned path would infer a latch.
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (enable && !reset) begin
            if (wr_req && rd_req) begin
                wr_gnt = (rr_last == LAST_RD);
                rd_gnt = (rr_last == LAST_WR);
            end else begin
                wr_gnt = wr_req;
                rd_gnt = rd_req;
            end
        end
    end

    // Remember the winner of each accepted transfer for the next contention.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            rr_last <= LAST_RD;
        end else if (wr_xfer) begin
            rr_last <= LAST_WR;
        end else if (rd_xfer) begin
            rr_last <= LAST_RD;
        end
    end
`endif

    assign wr_xfer = wr_req && wr_gnt;
    assign rd_xfer = rd_req && rd_gnt;

    // Buffer next-state: reader first, then writer end, then writer start.
    always_comb begin
        rd_sel_nxt     = rd_buf_sel;
        wr_sel_nxt     = wr_buf_sel;
        done_valid_nxt = done_valid;
        done_sel_nxt   = done_sel;
        wr_active_nxt  = wr_active;
        drop_nxt       = 1'b0;
        repeat_nxt     = 1'b0;
        if (enable) begin
            // The reader sees the done state as it was before this cycle.
            if (rd_frame_start) begin
                if (done_valid && !(wr_active && (done_sel == wr_buf_sel))) begin
                    rd_sel_nxt     = done_sel;
                    done_valid_nxt = 1'b0;
                end else begin
                    repeat_nxt = 1'b1;
                end
            end
            if (wr_frame_end) begin
                done_sel_nxt   = wr_buf_sel;
                done_valid_nxt = 1'b1;
                wr_active_nxt  = 1'b0;
            end
            // The writer always takes the buffer the reader is not using.
            if (wr_frame_start) begin
                wr_sel_nxt    = ~rd_sel_nxt;
                wr_active_nxt = 1'b1;
                if (done_valid_nxt && (done_sel_nxt == ~rd_sel_nxt)) begin
                    drop_nxt       = 1'b1;
                    done_valid_nxt = 1'b0;
                end
            end
        end
    end

    // Buffer state register and the one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_buf_sel   <= 1'b1;
            rd_buf_sel   <= 1'b0;
            done_valid   <= 1'b0;
            done_sel     <= 1'b0;
            wr_active    <= 1'b0;
            frame_drop   <= 1'b0;
            frame_repeat <= 1'b0;
        end else begin
            wr_buf_sel   <= wr_sel_nxt;
            rd_buf_sel   <= rd_sel_nxt;
            done_valid   <= done_valid_nxt;
            done_sel     <= done_sel_nxt;
            wr_active    <= wr_active_nxt;
            frame_drop   <= drop_nxt;
            frame_repeat <= repeat_nxt;
        end
    end

    // SRAM pin register: issue the accepted command, otherwise go idle and
    // hold address and data so the pads do not toggle needlessly.
    always_ff @(posedge clk) begin
        if (reset) begin
            sram_addr     <= '0;
            sram_ceb      <= 1'b1;
            sram_web      <= 1'b1;
            sram_oeb      <= 1'b1;
            sram_wdata    <= '0;
            sram_wdata_oe <= 1'b0;
        end else if (wr_xfer) begin
            sram_addr     <= (wr_sel_nxt ? addr1 : addr0) + wr_offset;
            sram_ceb      <= 1'b0;
            sram_web      <= 1'b0;
            sram_oeb      <= 1'b1;
            sram_wdata    <= wr_data;
            sram_wdata_oe <= 1'b1;
        end else if (rd_xfer) begin
            sram_addr     <= (rd_sel_nxt ? addr1 : addr0) + rd_offset;
            sram_ceb      <= 1'b0;
            sram_web      <= 1'b1;
            sram_oeb      <= 1'b0;
            sram_wdata_oe <= 1'b0;
        end else begin
            sram_ceb      <= 1'b1;
            sram_web      <= 1'b1;
            sram_oeb      <= 1'b1;
            sram_wdata_oe <= 1'b0;
        end
    end

    // Read return: track each read through the SRAM latency, then capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vpipe <= '0;
            rd_dv    <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_vpipe[0] <= rd_xfer;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vpipe[i] <= rd_vpipe[i-1];
            end
            rd_dv <= rd_vpipe[RD_LATENCY-1];
            if (rd_vpipe[RD_LATENCY-1]) begin
                rd_data <= sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Self-checking bench for sram_frame_arbiter (RD_LATENCY = 2).
// Commands and read returns are predicted when stimulus is driven and are
// compared by a monitor when the DUT is due to produce them.
module tb_sram_frame_arbiter;

    localparam int AW = 21;
    localparam int DW = 16;
    localparam logic [AW-1:0] ADDR0 = 21'h000100;
    localparam logic [AW-1:0] ADDR1 = 21'h002000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic [AW-1:0] addr0 = ADDR0;
    logic [AW-1:0] addr1 = ADDR1;
    logic          wr_frame_start = 1'b0;
    logic          wr_frame_end = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_offset = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_gnt;
    logic          rd_frame_start = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_offset = '0;
    logic          rd_gnt;
    logic          rd_dv;
    logic [DW-1:0] rd_data;
    logic          wr_buf_sel;
    logic          rd_buf_sel;
    logic          frame_drop;
    logic          frame_repeat;
    logic [AW-1:0] sram_addr;
    logic          sram_ceb;
    logic          sram_web;
    logic          sram_oeb;
    logic [DW-1:0] sram_wdata;
    logic          sram_wdata_oe;
    logic [DW-1:0] sram_rdata = '0;

    sram_frame_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .addr0(addr0), .addr1(addr1),
        .wr_frame_start(wr_frame_start), .wr_frame_end(wr_frame_end),
        .wr_req(wr_req), .wr_offset(wr_offset), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_frame_start(rd_frame_start), .rd_req(rd_req), .rd_offset(rd_offset),
        .rd_gnt(rd_gnt), .rd_dv(rd_dv), .rd_data(rd_data),
        .wr_buf_sel(wr_buf_sel), .rd_buf_sel(rd_buf_sel),
        .frame_drop(frame_drop), .frame_repeat(frame_repeat),
        .sram_addr(sram_addr), .sram_ceb(sram_ceb), .sram_web(sram_web),
        .sram_oeb(sram_oeb), .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe),
        .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    typedef struct {
        logic en;
        logic w;
        logic r;
        logic ew;
        logic er;
    } vec_t;

    cmd_t cmd_q[$];
    rd_t  rd_q[$];
    vec_t vecs[$];

    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    logic m_wr_sel = 1'b1;
    logic m_rd_sel = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM contents: a fixed pattern per address.
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 16'h5A5A;
    endfunction

    // SRAM model: data appears one cycle after the read command on the pins.
    always @(posedge clk) begin
        if (!sram_ceb && !sram_oeb) sram_rdata <= rom_word(sram_addr);
    end

    function automatic logic [AW-1:0] base(input logic sel);
        return sel ? ADDR1 : ADDR0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compares pins and read returns against the predictions.
    initial begin
        cmd_t c;
        rd_t  r;
        forever begin
            @(posedge clk);
            #2;
            while (cmd_q.size() != 0 && cmd_q[0].due < cyc) begin
                c = cmd_q.pop_front();
                check("cmd_missed_due", cyc, c.due);
            end
            if (cmd_q.size() != 0 && cmd_q[0].due == cyc) begin
                c = cmd_q.pop_front();
                check("cmd_ceb", sram_ceb, 0);
                check("cmd_web", sram_web, !c.is_wr);
                check("cmd_oeb", sram_oeb, c.is_wr);
                check("cmd_addr", sram_addr, c.addr);
                check("cmd_wdata_oe", sram_wdata_oe, c.is_wr);
                if (c.is_wr) check("cmd_wdata", sram_wdata, c.data);
            end else begin
                check("idle_ceb", sram_ceb, 1);
                check("idle_wdata_oe", sram_wdata_oe, 0);
            end
            while (rd_q.size() != 0 && rd_q[0].due < cyc) begin
                r = rd_q.pop_front();
                check("rd_missed_due", cyc, r.due);
            end
            if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
                r = rd_q.pop_front();
                check("rd_dv", rd_dv, 1);
                check("rd_data", rd_data, r.data);
            end else begin
                check("rd_dv_idle", rd_dv, 0);
            end
        end
    end

    task automatic flush_from(input int due_min);
        for (int i = cmd_q.size() - 1; i >= 0; i--) if (cmd_q[i].due >= due_min) cmd_q.delete(i);
        for (int i = rd_q.size() - 1; i >= 0; i--) if (rd_q[i].due >= due_min) rd_q.delete(i);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset with both requests pending: grants must stay low throughout.
    task automatic do_reset();
        reset = 1'b1;
        wr_req = 1'b1;
        rd_req = 1'b1;
        wr_frame_start = 1'b0;
        wr_frame_end = 1'b0;
        rd_frame_start = 1'b0;
        flush_from(cyc + 1);
        #3;
        check("gnt_in_reset", {wr_gnt, rd_gnt}, 0);
        step();
        step();
        reset = 1'b0;
        wr_req = 1'b0;
        rd_req = 1'b0;
        m_wr_sel = 1'b1;
        m_rd_sel = 1'b0;
    endtask

    // One request cycle: check grants and predict the resulting traffic.
    task automatic drive(input logic en, input logic w, input logic r,
                         input logic [AW-1:0] woff, input logic [DW-1:0] wd,
                         input logic [AW-1:0] roff, input logic ew, input logic er,
                         input string tag);
        enable = en;
        wr_req = w;
        rd_req = r;
        wr_offset = woff;
        wr_data = wd;
        rd_offset = roff;
        #3;
        check({tag, "_wr_gnt"}, wr_gnt, ew);
        check({tag, "_rd_gnt"}, rd_gnt, er);
        if (ew) cmd_q.push_back('{due: cyc + 1, is_wr: 1'b1, addr: base(m_wr_sel) + woff, data: wd});
        if (er) begin
            cmd_q.push_back('{due: cyc + 1, is_wr: 1'b0, addr: base(m_rd_sel) + roff, data: '0});
            rd_q.push_back('{due: cyc + 3, data: rom_word(base(m_rd_sel) + roff)});
        end
        step();
    endtask

    task automatic idle(input int n);
        wr_req = 1'b0;
        rd_req = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_drain();
        idle(1);
        for (int i = 0; i < 20 && (cmd_q.size() != 0 || rd_q.size() != 0); i++) step();
        check("drain_outstanding", cmd_q.size() + rd_q.size(), 0);
    endtask

    task automatic pulse(input logic ws, input logic we, input logic rs);
        wr_frame_start = ws;
        wr_frame_end = we;
        rd_frame_start = rs;
        step();
        wr_frame_start = 1'b0;
        wr_frame_end = 1'b0;
        rd_frame_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Grant-pattern table: {enable, wr_req, rd_req, exp wr_gnt, exp rd_gnt}.
`ifdef SRAM_ARB_WR_PRIORITY_EN
        for (int i = 0; i < 6; i++) vecs.push_back('{1, 1, 1, 1, 0});
        vecs.push_back('{1, 0, 1, 0, 1});
        vecs.push_back('{1, 1, 1, 1, 0});
        vecs.push_back('{0, 1, 1, 0, 0});
        vecs.push_back('{1, 1, 1, 1, 0});
        vecs.push_back('{1, 1, 0, 1, 0});
        vecs.push_back('{1, 1, 1, 1, 0});
`else
        for (int i = 0; i < 3; i++) begin
            vecs.push_back('{1, 1, 1, 1, 0});
            vecs.push_back('{1, 1, 1, 0, 1});
        end
        vecs.push_back('{1, 0, 1, 0, 1});
        vecs.push_back('{1, 1, 1, 1, 0});
        vecs.push_back('{0, 1, 1, 0, 0});
        vecs.push_back('{1, 1, 1, 0, 1});
        vecs.push_back('{1, 1, 0, 1, 0});
        vecs.push_back('{1, 1, 1, 0, 1});
`endif
        vecs.push_back('{1, 0, 0, 0, 0});

        // Reset values.
        do_reset();
        check("rst_ceb", sram_ceb, 1);
        check("rst_web", sram_web, 1);
        check("rst_oeb", sram_oeb, 1);
        check("rst_addr", sram_addr, 0);
        check("rst_wdata", sram_wdata, 0);
        check("rst_wdata_oe", sram_wdata_oe, 0);
        check("rst_rd_dv", rd_dv, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_wr_buf_sel", wr_buf_sel, 1);
        check("rst_rd_buf_sel", rd_buf_sel, 0);
        check("rst_frame_drop", frame_drop, 0);
        check("rst_frame_repeat", frame_repeat, 0);

        // Writes only: offsets 0..3 into buffer 1.
        for (int i = 0; i < 4; i++)
            drive(1, 1, 0, AW'(i), 16'hA000 + DW'(i), '0, 1, 0, "wr_only");
        // Reads only: offsets 5,6 from buffer 0.
        drive(1, 0, 1, '0, '0, AW'(5), 0, 1, "rd_only");
        drive(1, 0, 1, '0, '0, AW'(6), 0, 1, "rd_only");
        wait_drain();

        // Arbitration table, starting from reset.
        do_reset();
        foreach (vecs[i])
            drive(vecs[i].en, vecs[i].w, vecs[i].r, AW'(i), 16'hB000 + DW'(i), AW'(8 + i),
                  vecs[i].ew, vecs[i].er, $sformatf("vec%0d", i));
        wait_drain();

        // Complete a frame into buffer 1, reader takes it, writer moves to 0.
        do_reset();
        pulse(1, 0, 0);
        check("seq_wr_sel_first", wr_buf_sel, 1);
        check("seq_no_drop_first", frame_drop, 0);
        pulse(0, 1, 0);
        pulse(0, 0, 1);
        check("seq_rd_takes_1", rd_buf_sel, 1);
        check("seq_no_repeat", frame_repeat, 0);
        pulse(1, 0, 0);
        check("seq_wr_moves_0", wr_buf_sel, 0);
        // A frame end while disabled is ignored, so the reader repeats.
        enable = 1'b0;
        pulse(0, 1, 0);
        enable = 1'b1;
        pulse(0, 0, 1);
        check("frozen_repeat", frame_repeat, 1);
        check("frozen_rd_sel", rd_buf_sel, 1);
        step();
        check("frozen_repeat_end", frame_repeat, 0);

        // Two frames completed without a read: drop at the second start.
        do_reset();
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        check("drop_not_yet", frame_drop, 0);
        pulse(1, 0, 0);
        check("drop_pulse", frame_drop, 1);
        check("drop_wr_sel", wr_buf_sel, 1);
        step();
        check("drop_pulse_end", frame_drop, 0);

        // Reader starts while the writer is mid-frame with nothing done.
        do_reset();
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        check("repeat_pulse", frame_repeat, 1);
        check("repeat_rd_sel", rd_buf_sel, 0);
        step();
        check("repeat_pulse_end", frame_repeat, 0);

        // Same-cycle end and reader start: reader sees the old done state.
        do_reset();
        pulse(1, 0, 0);
        pulse(0, 1, 1);
        check("end_rd_same_repeat", frame_repeat, 1);
        check("end_rd_same_rd_sel", rd_buf_sel, 0);
        pulse(0, 0, 1);
        check("end_rd_later_rd_sel", rd_buf_sel, 1);

        // Same-cycle reader and writer starts: writer follows the new reader.
        do_reset();
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        pulse(1, 0, 1);
        check("both_start_rd_sel", rd_buf_sel, 1);
        check("both_start_wr_sel", wr_buf_sel, 0);
        check("both_start_no_drop", frame_drop, 0);
        check("both_start_no_repeat", frame_repeat, 0);

        // Buffer 0 completes; a read accepted with rd_frame_start uses buffer 0.
        pulse(0, 1, 0);
        rd_frame_start = 1'b1;
        m_rd_sel = 1'b0;
        drive(1, 0, 1, '0, '0, AW'(3), 0, 1, "rd_at_start");
        rd_frame_start = 1'b0;
        check("rd_at_start_sel", rd_buf_sel, 0);
        wait_drain();

        // Reset in the middle of a read burst drops all outstanding reads.
        do_reset();
        for (int i = 0; i < 3; i++)
            drive(1, 0, 1, '0, '0, AW'(20 + i), 0, 1, "burst");
        do_reset();
        for (int i = 0; i < 6; i++) begin
            check("rd_dv_after_reset", rd_dv, 0);
            step();
        end
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
